// File: rtl/div_bcd_formatter.sv
// div_bcd_formatter
//   Converts the 16-bit quotient and remainder of the ALU divider into packed
//   BCD for the display/readout stage. It uses one shared double-dabble
//   (shift-and-add-3) engine, so the quotient is converted first and the
//   remainder second.
//
// Ports
//   clk        : single clock, rising edge
//   reset_a    : asynchronous active-high reset
//   done       : divider completion pulse (qualifies quotient/remainder/overflow)
//   quotient   : divider quotient, unsigned
//   remainder  : divider remainder, unsigned
//   overflow   : divider overflow / divide-by-zero flag
//   q_bcd      : packed BCD quotient, digit 0 in [3:0]
//   r_bcd      : packed BCD remainder
//   ovf        : last reported result was an overflow
//   valid      : one-cycle strobe, q_bcd/r_bcd/ovf just updated
//   busy       : conversion in progress, done is not accepted
//   lost       : sticky, a done was dropped while busy (cleared by reset only)
//   dbg_state  : current FSM state (IDLE=0, CONV_Q=1, CONV_R=2)
//
// Handshake: the producer has no back-pressure. A done sampled while busy=0
//   is accepted. A done sampled while busy=1 is dropped and sets lost.
//   valid is a single-cycle strobe with no ready. The consumer must take
//   the result in that cycle, although the outputs hold their values until
//   the next valid.
module div_bcd_formatter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_a,
  input  logic                  done,
  input  logic [WIDTH-1:0]      quotient,
  input  logic [WIDTH-1:0]      remainder,
  input  logic                  overflow,
  output logic [DIGITS*4-1:0]   q_bcd,
  output logic [DIGITS*4-1:0]   r_bcd,
  output logic                  ovf,
  output logic                  valid,
  output logic                  busy,
  output logic                  lost,
  output logic [1:0]            dbg_state
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_R = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   qint_q, qint_d;
  logic [BW-1:0]   q_bcd_q, q_bcd_d;
  logic [BW-1:0]   r_bcd_q, r_bcd_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic            lost_q, lost_d;

  // One double-dabble step: add 3 to every digit >= 5, then shift
  // {acc, sr} left by one bit.
  logic [BW-1:0]    acc_adj;
  logic [BW-1:0]    acc_shift;
  logic [WIDTH-1:0] sr_shift;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) begin
        acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[BW-2:0], sr_q[WIDTH-1]};
    sr_shift  = {sr_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    hold_d  = hold_q;
    acc_d   = acc_q;
    qint_d  = qint_q;
    q_bcd_d = q_bcd_q;
    r_bcd_d = r_bcd_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    lost_d  = lost_q | (done && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (done) begin
          if (overflow) begin
            // Overflow is reported on the capture edge and needs no conversion.
            q_bcd_d = {BW{1'b1}};
            r_bcd_d = {BW{1'b1}};
            ovf_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            sr_d    = quotient;
            hold_d  = remainder;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CONV_Q;
          end
        end
      end

      CONV_Q: begin
        acc_d = acc_shift;
        sr_d  = sr_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // The quotient is complete. Park it and reuse the engine for the remainder.
          qint_d  = acc_shift;
          sr_d    = hold_q;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONV_R;
        end
      end

      CONV_R: begin
        acc_d = acc_shift;
        sr_d  = sr_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          q_bcd_d = qint_q;
          r_bcd_d = acc_shift;
          ovf_d   = 1'b0;
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      hold_q  <= '0;
      acc_q   <= '0;
      qint_q  <= '0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      acc_q   <= acc_d;
      qint_q  <= qint_d;
      q_bcd_q <= q_bcd_d;
      r_bcd_q <= r_bcd_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
    end
  end

  assign q_bcd     = q_bcd_q;
  assign r_bcd     = r_bcd_q;
  assign ovf       = ovf_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign lost      = lost_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Testbench for div_bcd_formatter: table vectors, corner-case sequences,
// and a random sweep. All results are compared through an expected queue.
module tb_div_bcd_formatter;

  logic        clk;
  logic        reset_a;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        overflow;
  logic [19:0] q_bcd;
  logic [19:0] r_bcd;
  logic        ovf;
  logic        valid;
  logic        busy;
  logic        lost;
  logic [1:0]  dbg_state;

  div_bcd_formatter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .reset_a   (reset_a),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .overflow  (overflow),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd),
    .ovf       (ovf),
    .valid     (valid),
    .busy      (busy),
    .lost      (lost),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  localparam int W = 41;  // {q_bcd, r_bcd, ovf}
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Decimal reference model, digit by digit with divide and modulo.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] res;
    int unsigned t;
    res = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      res[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!reset_a && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=%h/%h/%b required=no_valid", q_bcd, r_bcd, ovf);
      end else begin
        check("result", 64'({q_bcd, r_bcd, ovf}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Enter just after a rising edge (or at a falling edge). Return 1 time unit after the capture edge.
  task automatic send(input logic [15:0] q, input logic [15:0] r, input logic o,
                      input bit push, input logic [19:0] eq, input logic [19:0] er);
    quotient  = q;
    remainder = r;
    overflow  = o;
    done      = 1'b1;
    if (push) exp_q.push_back({eq, er, o});
    @(posedge clk);
    #1;
    done     = 1'b0;
    overflow = 1'b0;
  endtask

  // Count edges after the capture edge until valid is seen. Return at that falling edge.
  task automatic wait_valid(output int lat, output logic first_busy);
    lat = -1;
    first_busy = 1'bx;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i == 0) first_busy = busy;
      if (valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        o;
    logic [19:0] eq;
    logic [19:0] er;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int lat;
    logic fb;
    logic [15:0] rq, rr;
    logic ro;

    tbl[0] = '{16'd2,     16'd1,     1'b0, 20'h00002, 20'h00001};
    tbl[1] = '{16'd65535, 16'd0,     1'b0, 20'h65535, 20'h00000};
    tbl[2] = '{16'd1234,  16'd999,   1'b0, 20'h01234, 20'h00999};
    tbl[3] = '{16'd0,     16'd0,     1'b0, 20'h00000, 20'h00000};
    tbl[4] = '{16'd9999,  16'd10000, 1'b0, 20'h09999, 20'h10000};
    tbl[5] = '{16'd100,   16'd3,     1'b1, 20'hFFFFF, 20'hFFFFF};
    tbl[6] = '{16'd40960, 16'd59999, 1'b0, 20'h40960, 20'h59999};

    done = 1'b0;
    quotient = '0;
    remainder = '0;
    overflow = 1'b0;
    reset_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({q_bcd, r_bcd, ovf, valid, busy, lost}), 64'(0));
    reset_a = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors. Each checks latency, busy, and a single-cycle valid.
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].q, tbl[i].r, tbl[i].o, 1'b1, tbl[i].eq, tbl[i].er);
      wait_valid(lat, fb);
      check($sformatf("latency_%0d", i), 64'(lat), tbl[i].o ? 64'(0) : 64'(32));
      check($sformatf("busy_capture_%0d", i), 64'(fb), tbl[i].o ? 64'(0) : 64'(1));
      check($sformatf("busy_in_valid_%0d", i), 64'(busy), 64'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("valid_pulse_%0d", i), 64'(valid), 64'(0));
      @(posedge clk);
      #1;
    end

    // Overflow pulses on consecutive edges report on each edge.
    send(16'd1, 16'd1, 1'b1, 1'b1, 20'hFFFFF, 20'hFFFFF);
    send(16'd2, 16'd2, 1'b1, 1'b1, 20'hFFFFF, 20'hFFFFF);
    @(negedge clk);
    check("ovf_b2b_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;

    // Random sweep. Each done is driven in the previous valid cycle (33-cycle spacing).
    for (int k = 0; k < 1000; k++) begin
      rq = 16'($urandom_range(0, 65535));
      rr = 16'($urandom_range(0, 65535));
      ro = ($urandom_range(0, 15) == 0);
      send(rq, rr, ro, 1'b1, ro ? 20'hFFFFF : to_bcd(32'(rq)), ro ? 20'hFFFFF : to_bcd(32'(rr)));
      wait_valid(lat, fb);
      check("rand_latency", 64'(lat), ro ? 64'(0) : 64'(32));
    end
    check("rand_lost", 64'(lost), 64'(0));
    @(posedge clk);
    #1;

    // A done dropped while busy. A done in the valid cycle is accepted.
    send(16'd7, 16'd3, 1'b0, 1'b1, 20'h00007, 20'h00003);
    repeat (10) @(posedge clk);
    #1;
    send(16'd9, 16'd9, 1'b0, 1'b0, 20'h0, 20'h0);
    wait_valid(lat, fb);
    check("lost_latency", 64'(lat), 64'(21));
    send(16'd42, 16'd17, 1'b0, 1'b1, 20'h00042, 20'h00017);
    check("lost_sticky", 64'(lost), 64'(1));
    check("accept_in_valid_busy", 64'(busy), 64'(1));
    wait_valid(lat, fb);
    check("accept_in_valid_latency", 64'(lat), 64'(32));
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a conversion.
    send(16'd5, 16'd2, 1'b0, 1'b0, 20'h0, 20'h0);
    repeat (20) @(posedge clk);
    #2;
    reset_a = 1'b1;
    #1;
    check("async_reset", 64'({q_bcd, r_bcd, ovf, valid, busy, lost}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_a = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_idle", 64'({busy, lost}), 64'(0));
    send(16'd2, 16'd1, 1'b0, 1'b1, 20'h00002, 20'h00001);
    wait_valid(lat, fb);
    check("post_reset_latency", 64'(lat), 64'(32));
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
